// File: rtl/float_to_large_integer_pkg.sv
// float_to_large_integer_pkg
//   Shared constants, the binary32 field layout and the value-class code
//   used by the float -> wide fixed-point converter.
//   FTLI_OUT_W: 1 sign + 278 magnitude bits, LSB weight 2^-149.
package float_to_large_integer_pkg;

    localparam int FTLI_IN_W      = 32;
    localparam int FTLI_OUT_W     = 279;
    localparam int FTLI_EXP_W     = 8;
    localparam int FTLI_MANT_W    = 23;
    localparam int FTLI_FRAC_BITS = 149;
    localparam int FTLI_SIG_W     = FTLI_MANT_W + 1;
    localparam int FTLI_MAG_W     = FTLI_OUT_W - 1;

    typedef struct packed {
        logic                   sign;
        logic [FTLI_EXP_W-1:0]  exp;
        logic [FTLI_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        FINITE = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } ftli_class_e;

    // Class of an operand. Denormals count as FINITE; only all-zero
    // exponent and mantissa is ZERO.
    function automatic ftli_class_e ftli_classify(input fp32_t f);
        ftli_class_e c;
        if (f.exp == '1)
            c = (f.mant == '0) ? INF : NAN;
        else if (f.exp == '0 && f.mant == '0)
            c = ZERO;
        else
            c = FINITE;
        return c;
    endfunction

endpackage

// File: rtl/float_to_large_integer_shifter.sv
// ftli_shifter
//   Combinational left barrel shifter: zero-extends a SIG_W-bit significand
//   to OUT_W bits and shifts it left by sh (0 .. 2^SH_W-1).
//   Built as SH_W log stages; stage k shifts by 2^k when sh[k] is set.
//   Ports:
//     sig  in   SIG_W   significand
//     sh   in   SH_W    shift amount
//     mag  out  OUT_W   shifted magnitude
//   Upper bits shifted past OUT_W-1 are dropped; with binary32 operands the
//   top set bit never exceeds index 277, so nothing is lost.
module ftli_shifter #(
    parameter int SIG_W = 24,
    parameter int OUT_W = 278,
    parameter int SH_W  = 8
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [SH_W-1:0]  sh,
    output logic [OUT_W-1:0] mag
);

    logic [SH_W:0][OUT_W-1:0] stg;

    assign stg[0] = OUT_W'(sig);

    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        assign stg[k+1] = sh[k] ? (stg[k] << (1 << k)) : stg[k];
    end

    assign mag = stg[SH_W];

endmodule

// File: rtl/float_to_large_integer.sv
// float_to_large_integer
//   Converts an IEEE-754 binary32 operand into an exact two's-complement
//   fixed-point word (LSB = 2^-149). No rounding: every finite float fits.
//   Two-stage pipeline, latency 2, one result per cycle, no back-pressure.
//     stage 1: field decode + barrel shift -> magnitude, sign (+ class)
//     stage 2: conditional two's-complement negate (+ special-value mux)
//   Ports:
//     clk_i     in   1      clock, rising edge
//     arst_n_i  in   1      asynchronous active-low reset
//     valid_i   in   1      in_i carries an operand this cycle
//     in_i      in   IN_W   binary32 operand {sign, exp[7:0], mant[22:0]}
//     valid_o   out  1      out_o carries a result
//     out_o     out  OUT_W  two's-complement fixed-point result
//   Build option:
//     FLOAT_TO_LARGE_INT_SPECIAL_EN - decode exp=255 as Inf/NaN:
//       +Inf -> max positive, -Inf -> most negative, NaN -> 0.
//     Without it exp=255 is shifted like any other normal exponent.
module float_to_large_integer
    import float_to_large_integer_pkg::*;
#(
    parameter int IN_W  = FTLI_IN_W,
    parameter int OUT_W = FTLI_OUT_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  in_i,
    output logic             valid_o,
    output logic [OUT_W-1:0] out_o
);

    localparam int STAGES = 2;
    localparam int MAG_W  = OUT_W - 1;

    // ---------------------------------------------------------------
    // Valid pipeline: vld_pipe[n] marks stage n holding live data
    // ---------------------------------------------------------------
    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
    end

    assign valid_o = vld_pipe[STAGES];

    // ---------------------------------------------------------------
    // Stage 1: decode and shift
    // ---------------------------------------------------------------
    fp32_t                  op;
    logic [FTLI_SIG_W-1:0]  sig;
    logic [FTLI_EXP_W-1:0]  sh;
    logic [MAG_W-1:0]       mag_d;

    assign op  = in_i;
    // Implicit one only for normals. Denormals share the exp=1 weight,
    // so both exp=0 and exp=1 use shift 0.
    assign sig = {op.exp != '0, op.mant};
    assign sh  = (op.exp == '0) ? '0 : op.exp - 8'd1;

    ftli_shifter #(
        .SIG_W (FTLI_SIG_W),
        .OUT_W (MAG_W),
        .SH_W  (FTLI_EXP_W)
    ) u_shifter (
        .sig (sig),
        .sh  (sh),
        .mag (mag_d)
    );

    logic [MAG_W-1:0] mag_q;
    logic             sign_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mag_q  <= '0;
            sign_q <= 1'b0;
        end else if (valid_i) begin
            mag_q  <= mag_d;
            sign_q <= op.sign;
        end
    end

`ifdef FLOAT_TO_LARGE_INT_SPECIAL_EN
    ftli_class_e cls_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            cls_q <= ZERO;
        else if (valid_i)
            cls_q <= ftli_classify(op);
    end
`endif

    // ---------------------------------------------------------------
    // Stage 2: apply sign
    // ---------------------------------------------------------------
    logic [OUT_W-1:0] mag_ext;
    logic [OUT_W-1:0] res;

    always_comb begin
        mag_ext = {1'b0, mag_q};
        // A zero magnitude negates to zero (carry out dropped), so -0.0
        // never yields a distinct negative-zero pattern.
        res     = sign_q ? (~mag_ext + OUT_W'(1)) : mag_ext;
`ifdef FLOAT_TO_LARGE_INT_SPECIAL_EN
        case (cls_q)
            INF:     res = sign_q ? {1'b1, {MAG_W{1'b0}}} : {1'b0, {MAG_W{1'b1}}};
            NAN:     res = '0;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            out_o <= '0;
        else if (vld_pipe[1])
            out_o <= res;
    end

endmodule

// File: tb/tb_float_to_large_integer.sv
// tb_float_to_large_integer
//   Table of directed vectors (with hand-derived expected words), a
//   mid-stream asynchronous reset sequence, then randomized traffic checked
//   against an arithmetic reference model. Every cycle checks valid_o, and
//   either the expected result or that out_o held its last value.
module tb_float_to_large_integer;

    localparam int W = 279;

    logic         clk;
    logic         arst_n;
    logic         valid_i;
    logic [31:0]  in_i;
    logic         valid_o;
    logic [W-1:0] out_o;

    float_to_large_integer dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .valid_i  (valid_i),
        .in_i     (in_i),
        .valid_o  (valid_o),
        .out_o    (out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  in;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Expectation for the operand sent on the previous cycle
    bit           pv    = 1'b0;
    logic [W-1:0] pexp  = '0;
    string        pname = "idle";
    logic [W-1:0] held  = '0;

    // Reference: value = sig * 2^(e-127-23); in units of 2^-149 that is
    // sig * 2^(e-1). Denormals are mant * 2^-149 directly.
    function automatic logic [W-1:0] model(input logic [31:0] f);
        bit           s;
        int           e;
        logic [W-1:0] m;
        logic [W-1:0] v;
        s = f[31];
        e = int'(f[30:23]);
        m = W'(f[22:0]);
`ifdef FLOAT_TO_LARGE_INT_SPECIAL_EN
        if (e == 255) begin
            if (m != 0) return '0;
            return s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        if (e == 0)
            v = m;
        else
            v = (m + (W'(1) << 23)) * (W'(1) << (e - 127 - 23 + 149));
        return s ? -v : v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle and check what the DUT shows for the previous one.
    task automatic cycle(input bit v, input logic [31:0] x, input logic [W-1:0] e, input string nm);
        valid_i = v;
        in_i    = x;
        @(posedge clk);
        #1;
        check({pname, " valid"}, W'(valid_o), W'(pv));
        if (pv) begin
            check(pname, out_o, pexp);
            held = pexp;
        end else begin
            check("hold", out_o, held);
        end
        pv    = v;
        pexp  = e;
        pname = nm;
    endtask

    vec_t         tbl[$];
    logic [W-1:0] one;
    logic [W-1:0] ffff;

    initial begin
        one  = W'(1);
        ffff = W'(24'hFFFFFF);
        arst_n  = 1'b0;
        valid_i = 1'b0;
        in_i    = '0;

        // Reset state while held in reset over clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", W'(valid_o), '0);
        check("reset out", out_o, '0);
        @(negedge clk);
        arst_n = 1'b1;

        tbl.push_back('{32'h00000001, one,                       "min denormal"});
        tbl.push_back('{32'h3F800000, one << 149,                "1.0"});
        tbl.push_back('{32'h40000000, one << 150,                "2.0"});
        tbl.push_back('{32'hBF000000, -(one << 148),             "-0.5"});
        tbl.push_back('{32'hBF800000, -(one << 149),             "-1.0"});
        tbl.push_back('{32'h80000000, '0,                        "-0.0"});
        tbl.push_back('{32'h00000000, '0,                        "+0.0"});
        tbl.push_back('{32'h7F7FFFFF, ffff << 253,               "max finite"});
        tbl.push_back('{32'hFF7FFFFF, -(ffff << 253),            "-max finite"});
        tbl.push_back('{32'h807FFFFF, -(W'(23'h7FFFFF)),         "-max denormal"});
        tbl.push_back('{32'h00800000, one << 23,                 "min normal"});
`ifdef FLOAT_TO_LARGE_INT_SPECIAL_EN
        tbl.push_back('{32'h7F800000, {1'b0, {(W-1){1'b1}}},     "+inf"});
        tbl.push_back('{32'hFF800000, {1'b1, {(W-1){1'b0}}},     "-inf"});
        tbl.push_back('{32'h7FC00000, '0,                        "nan"});
`else
        tbl.push_back('{32'h7F800000, one << 277,                "+inf raw"});
        tbl.push_back('{32'hFF800000, -(one << 277),             "-inf raw"});
        tbl.push_back('{32'h7FC00000, W'(2'b11) << 276,          "nan raw"});
`endif
        // Walking one: mantissa bits give 1<<i; exponent bit i gives
        // exp = 2^(i-23), placing the implicit one at bit 22 + 2^(i-23).
        for (int i = 0; i < 31; i++)
            tbl.push_back('{32'(1) << i,
                            (i < 23) ? (one << i) : (one << (22 + (1 << (i - 23)))),
                            $sformatf("walk%0d", i)});

        // Back-to-back application of the whole table
        for (int i = 0; i < tbl.size(); i++)
            cycle(1'b1, tbl[i].in, tbl[i].exp, tbl[i].name);
        // Idle cycles: out_o must keep the last result
        repeat (3) cycle(1'b0, 32'h3F800000, '0, "idle");

        // Valid gap between two operands
        cycle(1'b1, 32'h3F800000, one << 149, "gap a");
        cycle(1'b0, 32'h40000000, '0, "idle");
        cycle(1'b1, 32'hBF000000, -(one << 148), "gap b");
        cycle(1'b0, 32'h0, '0, "idle");

        // Asynchronous reset mid-stream with data in both stages
        cycle(1'b1, 32'h3F800000, one << 149, "pre-rst a");
        cycle(1'b1, 32'h40000000, one << 150, "pre-rst b");
        #2;
        arst_n = 1'b0;
        #1;
        check("async rst valid", W'(valid_o), '0);
        check("async rst out", out_o, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst hold valid", W'(valid_o), '0);
        check("rst hold out", out_o, '0);
        valid_i = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        pv   = 1'b0;
        held = '0;
        cycle(1'b0, 32'h0, '0, "idle");
        cycle(1'b0, 32'h0, '0, "idle");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] x;
            bit          v;
            x = $urandom;
            case ($urandom_range(0, 5))
                0: x[30:23] = 8'h00;
                1: x[30:23] = 8'hFF;
                2: x[30:23] = 8'hFE;
                3: x[22:0]  = '0;
                default: ;
            endcase
            v = ($urandom_range(0, 3) != 0);
            cycle(v, x, model(x), $sformatf("rand %h", x));
        end
        cycle(1'b0, 32'h0, '0, "idle");
        cycle(1'b0, 32'h0, '0, "idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
